sisc_fetch: RTL and testbench

Instruction-fetch stage for the SISC CPU, directly upstream of the control FSM. It owns the program counter, prefetches one instruction from instruction memory over a req/ack handshake, and loads the instruction register on the FSM's `ir_load`. It decodes `opcode`/`mm` for the FSM and applies the FSM's `pc_write`/`pc_sel`/`br_sel`/`pc_rst` commands. `fetch_stall` tells the FSM to hold its fetch state while memory is slow.

---
 rtl/sisc_pkg.sv | 25 ++
 rtl/sisc_pc_next.sv | 27 ++
 rtl/sisc_fetch.sv | 99 +++++++++
 tb/tb_sisc_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// SISC shared definitions: widths, instruction field positions
// and the prefetch-buffer state encoding.
package sisc_pkg;

  localparam int PC_W   = 16;
  localparam int IR_W   = 32;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam int OPC_W  = OPC_HI - OPC_LO + 1;
  localparam int MM_W   = MM_HI - MM_LO + 1;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } fetch_state_t;

endpackage

// File: rtl/sisc_pc_next.sv
// Next-PC mux/adder: PC+1, absolute imm, or PC+imm (mod 2^PC_W).
// Ports: pc, imm, pc_sel, br_sel in; pc_nxt out (combinational).
module sisc_pc_next
  import sisc_pkg::*;
(
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] imm,
  input  logic             pc_sel,
  input  logic             br_sel,
  output logic [PC_W-1:0]  pc_nxt
);

  logic [PC_W-1:0] ext;

  // imm is as wide as pc, so the plain add wraps
  // and handles negative offsets for free.
  assign ext = PC_W'(imm);

  always_comb begin
    pc_nxt = pc + PC_W'(1);
    if (pc_sel) begin
      if (br_sel) pc_nxt = ext;
      else        pc_nxt = pc + ext;
    end
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC fetch stage: PC, one-entry tagged prefetch buffer, IR.
// Ports: FSM cmds in, im_req/im_addr/im_ack/im_rdata bus, pc/ir/fields/fetch_stall out.
module sisc_fetch
  import sisc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_f,
  input  logic             pc_rst,
  input  logic             pc_write,
  input  logic             pc_sel,
  input  logic             br_sel,
  input  logic             ir_load,
  output logic             im_req,
  output logic [PC_W-1:0]  im_addr,
  input  logic             im_ack,
  input  logic [IR_W-1:0]  im_rdata,
  output logic [PC_W-1:0]  pc,
  output logic [IR_W-1:0]  ir,
  output logic [OPC_W-1:0] opcode,
  output logic [MM_W-1:0]  mm,
  output logic [IMM_W-1:0] imm,
  output logic             fetch_stall
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] buf_addr;
  logic [IR_W-1:0] buf_data;
  logic            hit;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign mm     = ir[MM_HI:MM_LO];
  assign imm    = ir[IMM_HI:IMM_LO];

  sisc_pc_next u_pc_next (
    .pc     (pc),
    .imm    (imm),
    .pc_sel (pc_sel),
    .br_sel (br_sel),
    .pc_nxt (pc_nxt)
  );

  // Value pc takes at the coming edge.
  always_comb begin
    pc_d = pc;
    if (pc_rst)        pc_d = '0;
    else if (pc_write) pc_d = pc_nxt;
  end

  assign hit         = (state == FULL) && (buf_addr == pc);
  assign fetch_stall = ir_load & ~hit;

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: state_nxt = BUSY;
      BUSY: begin
        // Returned word is kept only if it is
        // for the pc we will have next cycle.
        if (im_ack)
          state_nxt = (im_addr == pc_d) ? FULL : EMPTY;
      end
      FULL: begin
        if ((ir_load && hit) || (pc_d != buf_addr))
          state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state    <= EMPTY;
      pc       <= '0;
      ir       <= '0;
      im_req   <= 1'b0;
      im_addr  <= '0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_d;
      if (state == EMPTY) begin
        im_req  <= 1'b1;
        im_addr <= pc_d;
      end
      if (state == BUSY && im_ack) begin
        im_req   <= 1'b0;
        buf_data <= im_rdata;
        buf_addr <= im_addr;
      end
      if (ir_load && hit)
        ir <= buf_data;
    end
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Self-checking bench for sisc_fetch: table-driven fetch/branch
// rows plus hand sequences for redirect, reset and slow memory.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        pc_rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic        ir_load = 1'b0;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic        fetch_stall;

  sisc_fetch dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .pc_rst      (pc_rst),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .br_sel      (br_sel),
    .ir_load     (ir_load),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .pc          (pc),
    .ir          (ir),
    .opcode      (opcode),
    .mm          (mm),
    .imm         (imm),
    .fetch_stall (fetch_stall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h10000000;
      16'h0001: return 32'h20000001;
      16'h0002: return 32'h80000002;
      16'h0003: return 32'h3000000F;
      16'h0004: return 32'h9B000020;
      16'h000E: return 32'h50000040;
      16'h000F: return 32'h4100FFFE;
      16'h0020: return 32'h6000FFFE;
      16'h0040: return 32'hC0000040;
      16'hFFFE: return 32'h70000002;
      default:  return {16'hEEEE, a};
    endcase
  endfunction

  // Memory model: ack in the (lat+1)-th cycle that im_req is seen high.
  // Updates land 2ns after the falling edge, after the stimulus settles.
  int          lat = 0;
  int          cnt = 0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        late_ack = 1'b0;

  assign im_ack   = mem_ack | late_ack;
  assign im_rdata = late_ack ? 32'hDEADBEEF : mem_data;

  always begin
    @(negedge clk);
    #2;
    if (im_req) begin
      if (cnt == lat) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(im_addr);
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      cnt     = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit pw, input bit ps, input bit bs,
                     input bit pr);
    ir_load  = 1'b0;
    pc_write = pw;
    pc_sel   = ps;
    br_sel   = bs;
    pc_rst   = pr;
    @(negedge clk);
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
  endtask

  // FSM fetch state: hold ir_load; pc_write only once not stalled.
  task automatic fetch_one(output int stalls, output bit moved);
    logic [31:0] ir0;
    bit done;
    ir0    = ir;
    stalls = 0;
    moved  = 1'b0;
    done   = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      ir_load  = 1'b1;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      #1;
      if (!fetch_stall) begin
        pc_write = 1'b1;
        done     = 1'b1;
      end else begin
        stalls++;
      end
      @(negedge clk);
      if (!done && ir !== ir0) moved = 1'b1;
    end
    ir_load  = 1'b0;
    pc_write = 1'b0;
    chk("fetch done in budget", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_req(input logic [15:0] a, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (im_req && im_addr == a) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  localparam logic [1:0] OP_F  = 2'd0;
  localparam logic [1:0] OP_JA = 2'd1;
  localparam logic [1:0] OP_JR = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] pc;
    logic [31:0] ir;
    bit          chk_addr;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int st;
    bit mv;
    bit ok;

    tbl[0]  = '{OP_F,  16'h0001, 32'h10000000, 1'b0, 16'h0};
    tbl[1]  = '{OP_F,  16'h0002, 32'h20000001, 1'b0, 16'h0};
    tbl[2]  = '{OP_F,  16'h0003, 32'h80000002, 1'b0, 16'h0};
    tbl[3]  = '{OP_F,  16'h0004, 32'h3000000F, 1'b0, 16'h0};
    tbl[4]  = '{OP_F,  16'h0005, 32'h9B000020, 1'b0, 16'h0};
    tbl[5]  = '{OP_JA, 16'h0020, 32'h9B000020, 1'b1, 16'h0020};
    tbl[6]  = '{OP_F,  16'h0021, 32'h6000FFFE, 1'b0, 16'h0};
    tbl[7]  = '{OP_JA, 16'hFFFE, 32'h6000FFFE, 1'b0, 16'h0};
    tbl[8]  = '{OP_F,  16'hFFFF, 32'h70000002, 1'b0, 16'h0};
    tbl[9]  = '{OP_JR, 16'h0001, 32'h70000002, 1'b0, 16'h0};
    tbl[10] = '{OP_JR, 16'h0003, 32'h70000002, 1'b0, 16'h0};
    tbl[11] = '{OP_F,  16'h0004, 32'h3000000F, 1'b0, 16'h0};
    tbl[12] = '{OP_JA, 16'h000F, 32'h3000000F, 1'b0, 16'h0};
    tbl[13] = '{OP_F,  16'h0010, 32'h4100FFFE, 1'b0, 16'h0};
    tbl[14] = '{OP_JR, 16'h000E, 32'h4100FFFE, 1'b0, 16'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst pc", pc, 32'h0);
    chk("rst ir", ir, 32'h0);
    chk("rst im_req", im_req, 32'h0);
    chk("rst im_addr", im_addr, 32'h0);
    chk("rst stall", fetch_stall, 32'h0);
    rst_f = 1'b0;

    // Sequential fetch and branches, 1-cycle memory
    for (int i = 0; i < 15; i++) begin
      case (tbl[i].op)
        OP_F:    fetch_one(st, mv);
        OP_JA:   cyc(1'b1, 1'b1, 1'b1, 1'b0);
        default: cyc(1'b1, 1'b1, 1'b0, 1'b0);
      endcase
      chk($sformatf("row%0d pc", i), pc, tbl[i].pc);
      chk($sformatf("row%0d ir", i), ir, tbl[i].ir);
      chk($sformatf("row%0d opcode", i), opcode, tbl[i].ir[31:28]);
      chk($sformatf("row%0d mm", i), mm, tbl[i].ir[27:24]);
      chk($sformatf("row%0d imm", i), imm, tbl[i].ir[15:0]);
      if (tbl[i].op == OP_F)
        chk($sformatf("row%0d ir held in stall", i), mv, 32'h0);
      if (tbl[i].chk_addr) begin
        chk($sformatf("row%0d im_req", i), im_req, 32'h1);
        chk($sformatf("row%0d im_addr", i), im_addr, tbl[i].addr);
      end
    end

    // Buffer fills at 0x000E; next fetch hits with no stall.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    fetch_one(st, mv);
    chk("hit stalls", st, 32'd0);
    chk("hit ir", ir, 32'h50000040);
    chk("hit pc", pc, 32'h000F);

    // pc_rst beats pc_write, then walk pc to 3 under slow memory.
    lat = 6;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("pc_rst priority", pc, 32'h0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pc walk", pc, 32'h0003);
    chk("no stall w/o load", fetch_stall, 32'h0);

    // Redirect to 0x0040 while the request for 0x0003 is in flight.
    wait_req(16'h0003, ok);
    chk("busy on 3", ok, 32'h1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("redir pc", pc, 32'h0040);
    chk("redir req held", im_req, 32'h1);
    chk("redir addr held", im_addr, 32'h0003);
    fetch_one(st, mv);
    chk("redir ir", ir, 32'hC0000040);
    chk("redir pc after", pc, 32'h0041);
    chk("redir ir held", mv, 32'h0);

    // Reset during BUSY, then an ack arriving with im_req low.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre-rst req", im_req, 32'h1);
    chk("pre-rst addr", im_addr, 32'h0041);
    rst_f = 1'b1;
    @(negedge clk);
    chk("mid-rst req", im_req, 32'h0);
    chk("mid-rst pc", pc, 32'h0);
    chk("mid-rst ir", ir, 32'h0);
    rst_f    = 1'b0;
    lat      = 0;
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    chk("late ack ir", ir, 32'h0);
    chk("fresh req", im_req, 32'h1);
    chk("fresh addr", im_addr, 32'h0);
    fetch_one(st, mv);
    chk("post-rst ir", ir, 32'h10000000);
    chk("post-rst pc", pc, 32'h0001);

    // Slow memory: ack in the 5th BUSY cycle. Stall covers the
    // EMPTY cycle plus lat+1 BUSY cycles = 6.
    rst_f = 1'b1;
    lat   = 4;
    @(negedge clk);
    rst_f = 1'b0;
    fetch_one(st, mv);
    chk("slow stalls", st, 32'd6);
    chk("slow ir held", mv, 32'h0);
    chk("slow ir", ir, 32'h10000000);
    chk("slow pc", pc, 32'h0001);
    chk("slow opcode", opcode, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
